// File: rtl/udp_tx_framer.sv
// udp_tx_framer: builds Ethernet II / IPv4 / UDP frames (no FCS) for an 8-bit AXI-Stream MAC TX port.
// Optional macro UDP_TX_VLAN_EN inserts an 802.1Q tag (vlan_tci input, 46-byte header, 64-byte minimum frame).
module udp_tx_framer #(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        gtx_clk,
  input  logic        resetn,
  input  logic [47:0] cfg_src_mac,
  input  logic [47:0] cfg_dst_mac,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
`ifdef UDP_TX_VLAN_EN
  input  logic [15:0] vlan_tci,
`endif
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        len_err,
  output logic [15:0] drop_cnt
);

`ifdef UDP_TX_VLAN_EN
  localparam int unsigned HDR_BYTES = 46;
  localparam int unsigned MIN_FRAME = 64;
`else
  localparam int unsigned HDR_BYTES = 42;
  localparam int unsigned MIN_FRAME = 60;
`endif
  localparam int unsigned HDR_W      = HDR_BYTES * 8;
  localparam logic [15:0] MAX_LEN    = 16'(MAX_PAYLOAD);
  localparam logic [15:0] MIN_PAY    = 16'(MIN_FRAME - HDR_BYTES);
  localparam logic [15:0] HDR_LAST   = 16'(HDR_BYTES - 1);
  localparam logic [15:0] CSUM_WORDS = 16'd10;

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD, FLUSH} state_e;

  state_e      state_q;
  logic        cmd_ready_q;
  logic        len_err_q;
  logic [15:0] drop_cnt_q;
  logic [15:0] ip_id_q;
  logic [19:0] sum_q;
  logic [15:0] idx_q;
  logic [15:0] pad_left_q;
  logic        bad_q;

  logic [15:0]      len_q;
  logic [47:0]      src_mac_q;
  logic [47:0]      dst_mac_q;
  logic [31:0]      src_ip_q;
  logic [31:0]      dst_ip_q;
  logic [15:0]      src_port_q;
  logic [15:0]      dst_port_q;
`ifdef UDP_TX_VLAN_EN
  logic [15:0]      vlan_q;
`endif
  logic [HDR_W-1:0] hdr_q;

  logic [15:0]      total_len;
  logic [15:0]      udp_len;
  logic [15:0]      csum_word;
  logic [16:0]      fold1;
  logic [15:0]      fold2;
  logic [15:0]      csum_final;
  logic [HDR_W-1:0] hdr_image;
  logic             last_byte;
  logic             short_frame;
  logic [15:0]      pad_total;
  logic             cmd_fire;
  logic             m_fire;

  assign total_len   = len_q + 16'd28;
  assign udp_len     = len_q + 16'd8;
  assign last_byte   = (idx_q == len_q - 16'd1);
  assign short_frame = (len_q < MIN_PAY);
  // Payload-region byte count a padded frame must reach (payload plus zero fill).
  assign pad_total   = short_frame ? MIN_PAY : len_q;
  assign cmd_fire    = cmd_valid && cmd_ready_q;
  assign m_fire      = m_axis_tvalid && m_axis_tready;

  // IPv4 header words in wire order; the checksum word itself counts as zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    csum_word = 16'h0000;
    case (idx_q[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = total_len;
      4'd2:    csum_word = ip_id_q;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL, 8'h11};
      4'd6:    csum_word = src_ip_q[31:16];
      4'd7:    csum_word = src_ip_q[15:0];
      4'd8:    csum_word = dst_ip_q[31:16];
      4'd9:    csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Two end-around-carry folds are enough for a 20-bit sum of ten words.
  assign fold1      = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
  assign fold2      = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_final = ~fold2;

  assign hdr_image = {dst_mac_q, src_mac_q,
`ifdef UDP_TX_VLAN_EN
                      16'h8100, vlan_q,
`endif
                      16'h0800,
                      16'h4500, total_len, ip_id_q, 16'h4000, TTL, 8'h11, csum_final,
                      src_ip_q, dst_ip_q,
                      src_port_q, dst_port_q, udp_len, 16'h0000};

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[HDR_W-1 -: 8];
      end
      PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        if (last_byte) begin
          if (!s_axis_tlast) begin
            m_axis_tlast = 1'b1;
            m_axis_tuser = 1'b1;
          end else if (!short_frame) begin
            m_axis_tlast = 1'b1;
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (pad_left_q == 16'd1);
        m_axis_tuser  = bad_q && (pad_left_q == 16'd1);
      end
      FLUSH:   s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge gtx_clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      len_err_q   <= 1'b0;
      drop_cnt_q  <= 16'h0000;
      ip_id_q     <= 16'h0000;
      sum_q       <= 20'h00000;
      idx_q       <= 16'h0000;
      pad_left_q  <= 16'h0000;
      bad_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every block sees pre-edge values.
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            if (cmd_len == 16'd0 || cmd_len > MAX_LEN) begin
              len_err_q <= 1'b1;
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              state_q     <= CSUM;
              cmd_ready_q <= 1'b0;
              idx_q       <= 16'd0;
              sum_q       <= 20'h00000;
            end
          end
        end
        CSUM: begin
          if (idx_q == CSUM_WORDS) begin
            state_q <= HDR;
            idx_q   <= 16'd0;
          end else begin
            sum_q <= sum_q + {4'h0, csum_word};
            idx_q <= idx_q + 16'd1;
          end
        end
        HDR: begin
          if (m_fire) begin
            if (idx_q == HDR_LAST) begin
              state_q <= PAYLOAD;
              idx_q   <= 16'd0;
            end else begin
              idx_q <= idx_q + 16'd1;
            end
          end
        end
        PAYLOAD: begin
          if (m_fire) begin
            idx_q <= idx_q + 16'd1;
            if (last_byte && !s_axis_tlast) begin
              ip_id_q <= ip_id_q + 16'd1;
              state_q <= FLUSH;
            end else if (last_byte && !short_frame) begin
              ip_id_q     <= ip_id_q + 16'd1;
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
            end else if (last_byte || s_axis_tlast) begin
              state_q    <= PAD;
              pad_left_q <= pad_total - idx_q - 16'd1;
              bad_q      <= !last_byte;
              if (!last_byte) len_err_q <= 1'b1;
            end
          end
        end
        PAD: begin
          if (m_fire) begin
            pad_left_q <= pad_left_q - 16'd1;
            if (pad_left_q == 16'd1) begin
              ip_id_q     <= ip_id_q + 16'd1;
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            len_err_q   <= 1'b1;
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: wide datapath registers carry no reset; they are always loaded before the FSM reads them.
  always_ff @(posedge gtx_clk) begin
    if (state_q == IDLE && cmd_fire) begin
      len_q      <= cmd_len;
      src_mac_q  <= cfg_src_mac;
      dst_mac_q  <= cfg_dst_mac;
      src_ip_q   <= cfg_src_ip;
      dst_ip_q   <= cfg_dst_ip;
      src_port_q <= cfg_src_port;
      dst_port_q <= cfg_dst_port;
`ifdef UDP_TX_VLAN_EN
      vlan_q     <= vlan_tci;
`endif
    end
    if (state_q == CSUM && idx_q == CSUM_WORDS) begin
      hdr_q <= hdr_image;
    end else if (state_q == HDR && m_fire) begin
      hdr_q <= {hdr_q[HDR_W-9:0], 8'h00};
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign len_err   = len_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: expected beats are queued when a frame is started and checked as the DUT emits them.
module tb_udp_tx_framer;

  localparam logic [47:0] SRC_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] DST_MAC  = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
  localparam logic [31:0] DST_IP   = 32'hC0A8_0002;
  localparam logic [15:0] SRC_PORT = 16'd5000;
  localparam logic [15:0] DST_PORT = 16'd6000;

  logic        gtx_clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        len_err;
  logic [15:0] drop_cnt;

  udp_tx_framer dut (
    .gtx_clk(gtx_clk), .resetn(resetn),
    .cfg_src_mac(SRC_MAC), .cfg_dst_mac(DST_MAC),
    .cfg_src_ip(SRC_IP), .cfg_dst_ip(DST_IP),
    .cfg_src_port(SRC_PORT), .cfg_dst_port(DST_PORT),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .len_err(len_err), .drop_cnt(drop_cnt)
  );

  always #4 gtx_clk = ~gtx_clk;

  typedef struct packed {logic last; logic user; logic [7:0] data;} beat_t;
  typedef struct packed {logic last; logic [7:0] data;} src_t;

  beat_t      exp_q[$];
  src_t       src_q[$];
  logic [7:0] got[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         hs_cyc = 0;
  int         len_err_seen = 0;
  bit         seen_first = 1'b1;
  bit         c_done = 1'b0;
  bit         bp_mode = 1'b0;
  bit         stalled = 1'b0;
  logic [9:0] held;
  logic [15:0] model_id = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then update stimulus just after the rising edge.
  task automatic cycle();
    bit s_fire;
    bit c_fire;
    beat_t e;
    @(negedge gtx_clk);
    cyc++;
    if (len_err) len_err_seen++;
    if (m_tvalid && !seen_first) begin
      seen_first = 1'b1;
      check("first_tvalid_latency", 32'(cyc - hs_cyc), 32'd12);
    end
    if (stalled) check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, held});
    stalled = m_tvalid && !m_tready;
    held    = {m_tlast, m_tuser, m_tdata};
    if (m_tvalid && m_tready) begin
      got.push_back(m_tdata);
      check("beat_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("beat_%0d", got.size()), {m_tlast, m_tuser, m_tdata}, e);
      end
    end
    s_fire = s_tvalid && s_tready;
    c_fire = cmd_valid && cmd_ready;
    if (c_fire) begin
      hs_cyc     = cyc;
      seen_first = 1'b0;
    end
    @(posedge gtx_clk);
    #1;
    if (c_fire) begin
      cmd_valid = 1'b0;
      c_done    = 1'b1;
    end
    if (s_fire && src_q.size() != 0) void'(src_q.pop_front());
    if (src_q.size() != 0) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0].data;
      s_tlast  = src_q[0].last;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 8'h00;
      s_tlast  = 1'b0;
    end
    m_tready = bp_mode ? !m_tready : 1'b1;
  endtask

  // Queue nin source bytes (tlast on the last one) and the frame the DUT must emit for a len command.
  task automatic start_frame(input int len, input int nin, input logic [7:0] seed);
    logic [335:0] hv;
    logic [31:0]  s;
    int           n_pay;
    int           target;
    int           emitted;
    beat_t        b;
    hv = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, 16'(len + 28), model_id, 16'h4000, 8'h40, 8'h11,
          16'h0000, SRC_IP, DST_IP, SRC_PORT, DST_PORT, 16'(len + 8), 16'h0000};
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'h0000, hv[223 - 16*w -: 16]};
    while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
    hv[143 -: 16] = ~s[15:0];
    for (int i = 0; i < 42; i++) exp_q.push_back({1'b0, 1'b0, hv[335 - 8*i -: 8]});
    for (int i = 0; i < nin; i++) src_q.push_back({i == nin - 1, 8'(seed + 8'(i))});
    n_pay = (nin < len) ? nin : len;
    for (int i = 0; i < n_pay; i++) exp_q.push_back({1'b0, 1'b0, 8'(seed + 8'(i))});
    if (nin > len) target = 42 + len;
    else           target = (42 + len < 60) ? 60 : 42 + len;
    emitted = 42 + n_pay;
    while (emitted < target) begin
      exp_q.push_back(10'h000);
      emitted++;
    end
    b      = exp_q.pop_back();
    b.last = 1'b1;
    b.user = (nin != len);
    exp_q.push_back(b);
    model_id++;
  endtask

  task automatic send_cmd(input logic [15:0] len);
    cmd_len   = len;
    cmd_valid = 1'b1;
    c_done    = 1'b0;
    for (int i = 0; i < 40 && !c_done; i++) cycle();
    check("cmd_accept", 32'(c_done), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || src_q.size() != 0); i++) cycle();
    repeat (3) cycle();
    check(tag, 32'(exp_q.size() + src_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] ip_sum();
    logic [31:0] s;
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'h0000, got[14 + 2*w], got[15 + 2*w]};
    while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
    return s[15:0];
  endfunction

  initial begin
    int   le0;
    logic [7:0] pad_or;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge gtx_clk);
    @(negedge gtx_clk);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge gtx_clk);
    #1 resetn = 1'b1;

    // Nominal 100-byte payload.
    got.delete(); le0 = len_err_seen;
    start_frame(100, 100, 8'h00);
    send_cmd(16'd100);
    wait_drain("nominal_drain", 2000);
    check("nominal_len", 32'(got.size()), 32'd142);
    check("nominal_total_len", {got[16], got[17]}, 32'h0080);
    check("nominal_udp_len", {got[38], got[39]}, 32'h006C);
    check("nominal_ip_csum", 32'(ip_sum()), 32'hFFFF);
    check("nominal_ip_id", {got[18], got[19]}, 32'd0);
    check("nominal_len_err", 32'(len_err_seen - le0), 32'd0);

    // Short frame padded to 60 bytes.
    got.delete();
    start_frame(4, 4, 8'hA0);
    send_cmd(16'd4);
    wait_drain("short_drain", 2000);
    check("short_len", 32'(got.size()), 32'd60);
    pad_or = 8'h00;
    for (int i = 46; i < 60; i++) pad_or = pad_or | got[i];
    check("short_pad_zero", 32'(pad_or), 32'd0);
    check("short_ip_id", {got[18], got[19]}, 32'd1);

    // Backpressure: m_axis_tready toggles every cycle.
    got.delete(); bp_mode = 1'b1;
    start_frame(64, 64, 8'h40);
    send_cmd(16'd64);
    wait_drain("bp_drain", 3000);
    bp_mode = 1'b0; m_tready = 1'b1;
    check("bp_len", 32'(got.size()), 32'd106);

    // Early tlast on the 10th of 20 bytes.
    got.delete(); le0 = len_err_seen;
    start_frame(20, 10, 8'h10);
    send_cmd(16'd20);
    wait_drain("early_drain", 2000);
    check("early_len", 32'(got.size()), 32'd62);
    check("early_len_err", 32'(len_err_seen - le0), 32'd1);

    // Overrun: 12 input bytes for len=8.
    got.delete(); le0 = len_err_seen;
    start_frame(8, 12, 8'h80);
    send_cmd(16'd8);
    wait_drain("overrun_drain", 2000);
    check("overrun_len", 32'(got.size()), 32'd50);
    check("overrun_len_err", 32'(len_err_seen - le0), 32'd1);

    // Rejected commands.
    got.delete(); le0 = len_err_seen;
    send_cmd(16'd0);
    send_cmd(16'd1473);
    repeat (5) cycle();
    check("reject_drop_cnt", 32'(drop_cnt), 32'd2);
    check("reject_len_err", 32'(len_err_seen - le0), 32'd2);
    check("reject_no_output", 32'(got.size()), 32'd0);

    // Reset in the middle of a payload.
    got.delete();
    start_frame(100, 100, 8'h20);
    send_cmd(16'd100);
    for (int i = 0; i < 500 && got.size() < 60; i++) cycle();
    check("rst_mid_progress", 32'(got.size() >= 60), 32'd1);
    resetn = 1'b0;
    @(posedge gtx_clk);
    #1;
    resetn = 1'b1;
    exp_q.delete(); src_q.delete();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    stalled = 1'b0; model_id = 16'd0;
    @(negedge gtx_clk);
    check("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_mid_tlast", 32'(m_tlast), 32'd0);
    check("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge gtx_clk);
    #1;
    got.delete();
    start_frame(10, 10, 8'h55);
    send_cmd(16'd10);
    wait_drain("after_rst_drain", 2000);
    check("after_rst_len", 32'(got.size()), 32'd60);
    check("after_rst_ip_id", {got[18], got[19]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
